// File: rtl/dac_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : dac_sample_fifo
//  Purpose  : Sample buffer and rate adapter between the DDS/sample source and
//             the AD5543 serial DAC driver. Prefills to START_LEVEL before
//             presenting samples, holds one sample on the output, repeats the
//             last sample on underrun and counts underruns. Optionally converts
//             two's-complement samples to offset binary for the unipolar DAC.
//  Ports    : fclk, reset_n (sync, active-low), flush, clr_stat
//             s_axis_*  : 16-bit sample input (AXI-stream slave)
//             m_axis_*  : held sample output, popped by 1-cycle tready strobe
//             level     : current FIFO occupancy
//             underrun_cnt : saturating underrun counter
//             running   : high while samples are being presented
//  Revision : 1.0 - initial release
// ============================================================================
module dac_sample_fifo #(
    parameter int DW          = 16,
    parameter int DEPTH       = 64,
    parameter int START_LEVEL = 32,
    parameter bit OFFSET_BIN  = 1'b1
) (
    input  logic                     fclk,
    input  logic                     reset_n,
    input  logic                     flush,
    input  logic                     clr_stat,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [DW-1:0]            s_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DW-1:0]            m_axis_tdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic [15:0]              underrun_cnt,
    output logic                     running
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [DW-1:0] c_MIDSCALE = {1'b1, {(DW-1){1'b0}}};
    localparam logic [LW-1:0] c_DEPTH    = LW'(DEPTH);
    localparam logic [LW-1:0] c_START    = LW'(START_LEVEL);
    localparam logic [15:0]   c_CNT_MAX  = 16'hFFFF;

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [DW-1:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [LW-1:0]   r_level;
    logic [DW-1:0]   r_hold;
    logic [15:0]     r_underrun_cnt;
    logic            r_in_rdy;      // gates tready until the first cycle after reset

    logic            w_push;
    logic            w_pop;
    logic            w_underrun;
    logic [DW-1:0]   w_head;
    logic [DW-1:0]   w_head_conv;

    // ------------------------------------------------------------------------
    // Output / handshake
    // ------------------------------------------------------------------------
    assign s_axis_tready = r_in_rdy && (r_level != c_DEPTH);
    assign m_axis_tvalid = (r_state == ST_RUN);
    assign running       = (r_state == ST_RUN);
    assign m_axis_tdata  = r_hold;
    assign level         = r_level;
    assign underrun_cnt  = r_underrun_cnt;

    // A flush discards any push accepted on the same cycle.
    assign w_push = s_axis_tvalid && s_axis_tready && !flush;

    assign w_head = r_mem[r_rd_ptr];

    generate
        if (OFFSET_BIN) begin : g_offset_bin
            assign w_head_conv = {~w_head[DW-1], w_head[DW-2:0]};
        end else begin : g_pass_through
            assign w_head_conv = w_head;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // State machine: next state and pop/underrun decisions
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_underrun  = 1'b0;
        case (r_state)
            ST_FILL: begin
                // Decision uses the registered level, so a push on this cycle
                // cannot start the output early.
                if (r_level >= c_START) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (m_axis_tready) begin
                    if (r_level != '0) begin
                        w_pop = 1'b1;
                    end else begin
                        w_underrun = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_FILL;
            end
        endcase
        if (flush) begin
            w_state_nxt = ST_FILL;
            w_pop       = 1'b0;
            w_underrun  = 1'b0;
        end
    end

    always_ff @(posedge fclk) begin
        if (!reset_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Sample storage (no reset so it can map onto RAM)
    // ------------------------------------------------------------------------
    always_ff @(posedge fclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_axis_tdata;
        end
    end

    // ------------------------------------------------------------------------
    // Pointers, occupancy, hold register, underrun counter
    // ------------------------------------------------------------------------
    always_ff @(posedge fclk) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_hold         <= c_MIDSCALE;
            r_underrun_cnt <= '0;
            r_in_rdy       <= 1'b0;
        end else begin
            r_in_rdy <= 1'b1;

            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_hold   <= c_MIDSCALE;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + AW'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                    r_hold   <= w_head_conv;
                end
                // A push into an empty FIFO during an underrun lands in the
                // FIFO; it is never bypassed straight into the hold register.
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
            end

            // Clearing takes precedence over a coincident underrun.
            if (clr_stat) begin
                r_underrun_cnt <= '0;
            end else if (w_underrun && (r_underrun_cnt != c_CNT_MAX)) begin
                r_underrun_cnt <= r_underrun_cnt + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dac_sample_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dac_sample_fifo
//  Purpose  : Self-checking bench for dac_sample_fifo. A queue-based reference
//             model predicts every output on every cycle; directed steps walk
//             through prefill, paced draining, underrun, full, wrap, flush,
//             stat clear and reset, followed by a randomized traffic phase.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dac_sample_fifo;

    localparam int DW     = 16;
    localparam int DEPTH  = 64;
    localparam int START  = 32;

    logic        fclk     = 1'b0;
    logic        reset_n  = 1'b0;
    logic        flush    = 1'b0;
    logic        clr_stat = 1'b0;
    logic        s_tvalid = 1'b0;
    logic [15:0] s_tdata  = 16'h0000;
    logic        m_tready = 1'b0;

    logic        s_tready;
    logic        m_tvalid;
    logic [15:0] m_tdata;
    logic [6:0]  level;
    logic [15:0] ucnt;
    logic        running;

    always #5 fclk = ~fclk;

    dac_sample_fifo #(
        .DW          (DW),
        .DEPTH       (DEPTH),
        .START_LEVEL (START),
        .OFFSET_BIN  (1'b1)
    ) dut (
        .fclk          (fclk),
        .reset_n       (reset_n),
        .flush         (flush),
        .clr_stat      (clr_stat),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tdata  (s_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tdata  (m_tdata),
        .level         (level),
        .underrun_cnt  (ucnt),
        .running       (running)
    );

    // Reference model state
    logic [15:0] q[$];
    bit          md_run  = 1'b0;
    bit          md_rdy  = 1'b0;
    logic [15:0] md_hold = 16'h8000;
    logic [15:0] md_cnt  = 16'h0000;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("s_tready", {31'd0, s_tready}, {31'd0, (md_rdy && (q.size() != DEPTH))});
        chk("m_tvalid", {31'd0, m_tvalid}, {31'd0, md_run});
        chk("running",  {31'd0, running},  {31'd0, md_run});
        chk("m_tdata",  {16'd0, m_tdata},  {16'd0, md_hold});
        chk("level",    {25'd0, level},    32'(q.size()));
        chk("ucnt",     {16'd0, ucnt},     {16'd0, md_cnt});
    endtask

    // Advance one clock: predict from current inputs, then compare after the edge.
    task automatic step();
        bit          push;
        bit          do_pop;
        bit          und;
        int          lvl;
        logic [15:0] d;
        push   = s_tvalid && md_rdy && (q.size() != DEPTH);
        lvl    = q.size();
        do_pop = 1'b0;
        und    = 1'b0;
        if (!reset_n) begin
            q.delete();
            md_run  = 1'b0;
            md_rdy  = 1'b0;
            md_hold = 16'h8000;
            md_cnt  = 16'h0000;
        end else begin
            md_rdy = 1'b1;
            if (flush) begin
                q.delete();
                md_run  = 1'b0;
                md_hold = 16'h8000;
            end else begin
                if (!md_run) begin
                    if (lvl >= START) begin
                        do_pop = 1'b1;
                        md_run = 1'b1;
                    end
                end else if (m_tready) begin
                    if (lvl > 0) do_pop = 1'b1;
                    else         und    = 1'b1;
                end
                if (do_pop) begin
                    d       = q.pop_front();
                    md_hold = d ^ 16'h8000;
                end
                if (push) q.push_back(s_tdata);
            end
            if (clr_stat)                          md_cnt = 16'h0000;
            else if (und && md_cnt != 16'hFFFF)    md_cnt = md_cnt + 16'd1;
        end
        @(posedge fclk);
        #1;
        check_all();
    endtask

    initial begin
        // ---------------- reset ----------------
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        chk("rst_tready", {31'd0, s_tready}, 32'd1);
        chk("rst_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("rst_tdata",  {16'd0, m_tdata},  32'h8000);
        chk("rst_level",  {25'd0, level},    32'd0);

        // ---------------- prefill 0x0000..0x001F ----------------
        for (int i = 0; i < 32; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'(i);
            step();
            if (i == 30) chk("fill_31_running", {31'd0, running}, 32'd0);
        end
        s_tvalid = 1'b0;
        chk("fill_32_still_fill", {31'd0, m_tvalid}, 32'd0);
        chk("fill_32_tdata",      {16'd0, m_tdata},  32'h8000);
        step();
        chk("start_running", {31'd0, running}, 32'd1);
        chk("start_tdata",   {16'd0, m_tdata}, 32'h8000);
        chk("start_level",   {25'd0, level},   32'd31);

        // ---------------- paced draining, then underruns ----------------
        for (int k = 1; k <= 31; k++) begin
            m_tready = 1'b1;
            step();
            m_tready = 1'b0;
            chk("drain_tdata", {16'd0, m_tdata}, 32'h8000 + 32'(k));
            repeat (23) step();
        end
        for (int k = 1; k <= 4; k++) begin
            m_tready = 1'b1;
            step();
            m_tready = 1'b0;
            chk("underrun_hold", {16'd0, m_tdata}, 32'h801F);
            chk("underrun_cnt",  {16'd0, ucnt},    32'(k));
            repeat (23) step();
        end

        // ---------------- fill to full, single pop ----------------
        s_tvalid = 1'b1;
        s_tdata  = 16'h7FFF;
        repeat (70) step();
        chk("full_level",  {25'd0, level},    32'd64);
        chk("full_tready", {31'd0, s_tready}, 32'd0);
        m_tready = 1'b1;
        step();
        m_tready = 1'b0;
        chk("pop_full_level",  {25'd0, level},    32'd63);
        chk("pop_full_tready", {31'd0, s_tready}, 32'd1);
        chk("pop_full_tdata",  {16'd0, m_tdata},  32'hFFFF);
        step();
        chk("refill_level", {25'd0, level}, 32'd64);
        s_tvalid = 1'b0;

        // ---------------- drain to 10, then push+pop across the wrap ----------------
        m_tready = 1'b1;
        repeat (54) step();
        chk("level_10", {25'd0, level}, 32'd10);
        for (int i = 0; i < 80; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'($urandom);
            step();
        end
        chk("pushpop_level", {25'd0, level}, 32'd10);
        m_tready = 1'b0;

        // ---------------- flush at level 20 ----------------
        for (int i = 0; i < 10; i++) begin
            s_tdata = 16'($urandom);
            step();
        end
        s_tvalid = 1'b0;
        chk("pre_flush_level", {25'd0, level}, 32'd20);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_level",  {25'd0, level},    32'd0);
        chk("flush_tvalid", {31'd0, m_tvalid}, 32'd0);
        chk("flush_tdata",  {16'd0, m_tdata},  32'h8000);
        chk("flush_ucnt",   {16'd0, ucnt},     32'd4);

        // ---------------- clr_stat coincident with an underrun ----------------
        for (int i = 0; i < 32; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'($urandom);
            step();
        end
        s_tvalid = 1'b0;
        step();
        m_tready = 1'b1;
        repeat (32) step();
        chk("ucnt_before_clr", {16'd0, ucnt}, 32'd5);
        clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        m_tready = 1'b0;
        chk("clr_during_underrun", {16'd0, ucnt}, 32'd0);

        // ---------------- randomized traffic ----------------
        for (int i = 0; i < 3000; i++) begin
            s_tvalid = ($urandom_range(0, 1) == 0);
            s_tdata  = 16'($urandom);
            m_tready = ($urandom_range(0, 5) == 0);
            flush    = ($urandom_range(0, 299) == 0);
            clr_stat = ($urandom_range(0, 199) == 0);
            step();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b0;
        flush    = 1'b0;
        clr_stat = 1'b0;

        // ---------------- reset pulse mid-RUN ----------------
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int i = 0; i < 32; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 16'($urandom);
            step();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        step();
        step();
        m_tready = 1'b0;
        chk("pre_reset_running", {31'd0, running}, 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("reset_running", {31'd0, running}, 32'd0);
        chk("reset_tdata",   {16'd0, m_tdata}, 32'h8000);
        chk("reset_level",   {25'd0, level},   32'd0);
        chk("reset_ucnt",    {16'd0, ucnt},    32'd0);
        step();
        chk("post_reset_tready", {31'd0, s_tready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
